// File: rtl/crossword_pkg.sv
// Shared definitions for the crossword highlight cursor: grid defaults,
// cursor FSM states and step-direction encodings.
package crossword_pkg;

    localparam int unsigned GRID_W_DEF = 15;
    localparam int unsigned GRID_H_DEF = 15;
    localparam int unsigned ROW_W_DEF  = 4;
    localparam int unsigned COL_W_DEF  = 4;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_LOW = 1'b1
    } hl_state_t;

    localparam logic DIR_ACROSS = 1'b0;
    localparam logic DIR_DOWN   = 1'b1;

endpackage

// File: rtl/hl_blink_timer.sv
// Frame-tick driven blink generator for the highlight cursor. A restart
// makes the cursor solid and begins a fresh half-period.
module hl_blink_timer #(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_tick,
    input  logic restart,
    output logic hl_on
);

    localparam logic [7:0] LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] count;

    // Count frame ticks; toggle visibility at the end of each half-period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            hl_on <= 1'b1;
        end else if (restart) begin
            count <= '0;
            hl_on <= 1'b1;
        end else if (frame_tick) begin
            if (count >= LAST) begin
                count <= '0;
                hl_on <= ~hl_on;
            end else begin
                count <= count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/crossword_hl_cursor.sv
// Crossword highlight cursor: one step per move_hl high period, across or
// down with carry and wrap, home to (0,0), and a frame-based blink enable.
module crossword_hl_cursor
    import crossword_pkg::*;
#(
    parameter int unsigned GRID_W       = GRID_W_DEF,
    parameter int unsigned GRID_H       = GRID_H_DEF,
    parameter int unsigned ROW_W        = ROW_W_DEF,
    parameter int unsigned COL_W        = COL_W_DEF,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             move_hl,
    input  logic             dir_down,
    input  logic             home,
    input  logic             frame_tick,
    output logic [ROW_W-1:0] hl_row,
    output logic [COL_W-1:0] hl_col,
    output logic             hl_on,
    output logic             hl_moved
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(GRID_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(GRID_W - 1);

    hl_state_t        state;
    logic [ROW_W-1:0] step_row;
    logic [COL_W-1:0] step_col;
    logic             do_step;
    logic             restart;

    assign do_step = (state == S_IDLE) && move_hl && !home;
    assign restart = home || do_step;

    // Next position for a single step; the minor axis carries into the major.
    always_comb begin
        step_row = hl_row;
        step_col = hl_col;
        if (hl_row > ROW_LAST || hl_col > COL_LAST) begin
            step_row = '0;
            step_col = '0;
        end else if (dir_down == DIR_ACROSS) begin
            if (hl_col < COL_LAST) begin
                step_col = hl_col + COL_W'(1);
            end else begin
                step_col = '0;
                step_row = (hl_row < ROW_LAST) ? hl_row + ROW_W'(1) : '0;
            end
        end else begin
            if (hl_row < ROW_LAST) begin
                step_row = hl_row + ROW_W'(1);
            end else begin
                step_row = '0;
                step_col = (hl_col < COL_LAST) ? hl_col + COL_W'(1) : '0;
            end
        end
    end

    // Cursor FSM: step on the first high cycle, then wait for move_hl low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            hl_row   <= '0;
            hl_col   <= '0;
            hl_moved <= 1'b0;
        end else begin
            hl_moved <= 1'b0;
            if (home) begin
                hl_row   <= '0;
                hl_col   <= '0;
                hl_moved <= (hl_row != '0) || (hl_col != '0);
                state    <= move_hl ? S_WAIT_LOW : S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (move_hl) begin
                            hl_row   <= step_row;
                            hl_col   <= step_col;
                            hl_moved <= 1'b1;
                            state    <= S_WAIT_LOW;
                        end
                    end
                    S_WAIT_LOW: begin
                        if (!move_hl) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    hl_blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk       (clk),
        .reset_n   (reset_n),
        .frame_tick(frame_tick),
        .restart   (restart),
        .hl_on     (hl_on)
    );

endmodule
